sync_fifo_param: RTL
====================

# sync_fifo_param

Single-clock, parametrised FIFO for the same byte-stream datapaths as the dual-clock FIFO, used where producer and consumer share one clock and no pointer synchroniser is needed. Generalises the existing design in data width and depth, and adds:
- a fill-level count;
- programmable almost-full and almost-empty flags;
- sticky overflow and underflow error flags;
- an optional first-word-fall-through read mode.

## Interface
Parameters:
- WIDTH, 8, data word width in bits
- ADDR, 3, address width; depth DEPTH = 2^ADDR words
- AF_THRESH, 6, almost_full asserted when level >= AF_THRESH (legal range 1..DEPTH)
- AE_THRESH, 2, almost_empty asserted when level <= AE_THRESH (legal range 0..DEPTH-1)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserts immediately, releases synchronously to clk by upstream logic)
- wrreq  in  1  write request
- data_in  in  WIDTH  write data, sampled with wrreq
- rdreq  in  1  read request
- data_out  out  WIDTH  read data
- rd_valid  out  1  data_out holds a newly read word
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_THRESH
- almost_empty  out  1  level <= AE_THRESH
- level  out  ADDR+1  number of stored words, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected
- clr_err  in  1  synchronous clear of overflow/underflow

## Operation
- Storage: DEPTH x WIDTH register array.
- Pointers: wr_ptr and rd_ptr are ADDR+1 bits each. The low ADDR bits index the array; the MSB is a wrap bit.
  - full when MSBs differ and the low bits are equal.
  - empty when the pointers are equal.
- Acceptance:
  - wr_acc = wrreq & (!full | rd_acc).
  - rd_acc = rdreq & !empty.
- Full with simultaneous wrreq and rdreq: both are accepted and level stays at DEPTH.
- Empty with simultaneous wrreq and rdreq: the write is accepted and the read is rejected.
- Level update: +1 on write only, -1 on read only, unchanged on both or neither.
- Status outputs: all flags and level are registered and derived from the next-state level, so they are exact in the cycle after the edge.
- Rejected write (wrreq & !wr_acc): overflow is set. Memory and wr_ptr are unchanged.
- Rejected read (rdreq & !rd_acc): underflow is set. data_out keeps its value and rd_valid is 0.
- Error flag clearing: clr_err clears overflow and underflow. If a set and clr_err occur in the same cycle, the set wins.
- Pointer wrap: pointers wrap modulo 2*DEPTH with no special case. Back-to-back full/empty cycles across the wrap must keep level exact.
- Reset values: wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, almost_empty=1, almost_full=0 (for AF_THRESH>=1), overflow=0, underflow=0, data_out=0, rd_valid=0. Array contents are not reset.
- Reset mid-operation: all stored data is discarded and outputs return to reset values asynchronously.

## Timing
- Write latency: a word written at edge N is readable (empty=0) after edge N.
- Standard mode:
  - data_out is registered and loaded on the edge where rd_acc=1. The word is valid after that edge.
  - rd_valid is 1 for exactly that following cycle.
  - Read latency is 1 cycle and data_out holds between reads.
- Throughput: one write and one read per cycle sustained.
- No combinational path from wrreq/rdreq to any output in standard mode.

## Configuration
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out = mem[rd_ptr] combinationally and rd_valid = !empty.
  - rdreq acts as a pop/acknowledge of the presented word.
  - A word written at edge N appears on data_out after edge N, with zero read latency.
  - The data_out reset value is don't-care while empty.
- Undefined: the standard registered mode as described in Operation and Timing.

## Test plan
- Reset, then 8 writes 0x01..0x08 (ADDR=3) -> after the 6th write almost_full=1; after the 8th full=1, level=8. A 9th write of 0x09 sets overflow=1, and level stays 8.
- Drain 8 reads -> data_out sequence 0x01..0x08, each with rd_valid one cycle after rdreq (standard mode). almost_empty asserts at level=2, empty at 0. A further read sets underflow=1 and data_out stays 0x08.
- Full, simultaneous wrreq(0xAA)+rdreq -> both accepted, level stays 8. 0xAA is read out last after 7 more reads.
- Empty, simultaneous wrreq(0x55)+rdreq -> underflow=1, level=1. The next read returns 0x55. Asserting clr_err together with a new rejected read keeps underflow=1; clr_err alone clears it.
- 40 cycles of random wrreq/rdreq crossing the pointer wrap several times -> level always equals the scoreboard count, and data order matches the model.
- With SYNC_FIFO_FWFT_EN: write 0x3C into an empty FIFO -> data_out=0x3C and rd_valid=1 in the next cycle, with no rdreq needed. A single rdreq pops it, giving empty=1.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with fill level, almost-full/empty and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module sync_fifo_param #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR      = 3,
  parameter int unsigned AF_THRESH = 6,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rdreq,
  output logic [WIDTH-1:0] data_out,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ADDR:0]    level,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int unsigned   DEPTH     = 1 << ADDR;
  localparam logic [ADDR:0] DEPTH_LVL = (ADDR + 1)'(DEPTH);
  localparam logic [ADDR:0] AF_LVL    = (ADDR + 1)'(AF_THRESH);
  localparam logic [ADDR:0] AE_LVL    = (ADDR + 1)'(AE_THRESH);
  localparam logic [ADDR:0] LVL_ONE   = (ADDR + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR:0]    wr_ptr_q, rd_ptr_q, level_q, level_d;
  logic             full_ptr, empty_ptr, wr_acc, rd_acc;
  logic             full_q, empty_q, af_q, ae_q, ovf_q, unf_q;

  // Acceptance is decided from pointer state only, so no input reaches an output.
  assign full_ptr  = (wr_ptr_q[ADDR] != rd_ptr_q[ADDR]) &&
                     (wr_ptr_q[ADDR-1:0] == rd_ptr_q[ADDR-1:0]);
  assign empty_ptr = (wr_ptr_q == rd_ptr_q);
  assign rd_acc    = rdreq & ~empty_ptr;
  assign wr_acc    = wrreq & (~full_ptr | rd_acc);

  always_comb begin
    level_d = level_q;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + LVL_ONE;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + LVL_ONE;
      level_q <= level_d;
      full_q  <= (level_d == DEPTH_LVL);
      empty_q <= (level_d == '0);
      af_q    <= (level_d >= AF_LVL);
      ae_q    <= (level_d <= AE_LVL);
      // A new error in the same cycle as clr_err wins over the clear.
      ovf_q   <= (ovf_q & ~clr_err) | (wrreq & ~wr_acc);
      unf_q   <= (unf_q & ~clr_err) | (rdreq & ~rd_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[ADDR-1:0]] <= data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = mem_q[rd_ptr_q[ADDR-1:0]];
  assign rd_valid = ~empty_q;
`else
  logic [WIDTH-1:0] dout_q;
  logic             rd_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (rd_acc) dout_q <= mem_q[rd_ptr_q[ADDR-1:0]];
      rd_valid_q <= rd_acc;
    end
  end

  assign data_out = dout_q;
  assign rd_valid = rd_valid_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
